// File: rtl/crank_wheel_gen.sv
// ============================================================================
// crank_wheel_gen : synthetic N-minus-M crank wheel pulse train generator.
// Optional cam output enabled by CRANK_WHEEL_GEN_CAM_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module crank_wheel_gen #(
    parameter int PER_WIDTH     = 24,
    parameter int TCNT_WIDTH    = 6,
    parameter int TEETH_TOTAL   = 60,
    parameter int TEETH_MISSING = 2,
    parameter int START_TOOTH   = 0,
    parameter int PER_MIN       = 4
`ifdef CRANK_WHEEL_GEN_CAM_EN
    ,
    parameter int CAM_TEETH     = 4
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [PER_WIDTH-1:0]  period,
    input  logic                  inv,
    output logic                  cap,
    output logic [TCNT_WIDTH-1:0] tooth_num,
    output logic                  gap,
    output logic                  rev_strobe,
    output logic                  running
`ifdef CRANK_WHEEL_GEN_CAM_EN
    ,
    output logic                  cam
`endif
);

    localparam logic [PER_WIDTH-1:0]  PER_MIN_W   = PER_WIDTH'(PER_MIN);
    localparam logic [TCNT_WIDTH-1:0] START_W     = TCNT_WIDTH'(START_TOOTH);
    localparam logic [TCNT_WIDTH-1:0] LAST_W      = TCNT_WIDTH'(TEETH_TOTAL - 1);
    localparam logic [TCNT_WIDTH-1:0] PRESENT_LIM = TCNT_WIDTH'(TEETH_TOTAL - TEETH_MISSING);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [PER_WIDTH-1:0]  scnt_q, scnt_d;
    logic [PER_WIDTH-1:0]  per_sh_q, per_sh_d;
    logic [PER_WIDTH-1:0]  per_clamp;
    logic [TCNT_WIDTH-1:0] tcnt_q, tcnt_d;
    logic                  cap_q, cap_d;
    logic                  gap_q, gap_d;
    logic                  rev_q, rev_d;
    logic                  run_q, run_d;
    logic                  present_d;
`ifdef CRANK_WHEEL_GEN_CAM_EN
    localparam logic [TCNT_WIDTH-1:0] CAM_W = TCNT_WIDTH'(CAM_TEETH);
    logic                  rp_q, rp_d;
    logic                  cam_q, cam_d;
`endif

    always_comb begin
        per_clamp = (period < PER_MIN_W) ? PER_MIN_W : period;
        state_d   = state_q;
        scnt_d    = scnt_q;
        tcnt_d    = tcnt_q;
        per_sh_d  = per_sh_q;
`ifdef CRANK_WHEEL_GEN_CAM_EN
        rp_d      = rp_q;
`endif
        case (state_q)
            IDLE: begin
                if (ena) begin
                    state_d  = RUN;
                    per_sh_d = per_clamp;
                    scnt_d   = '0;
                    tcnt_d   = START_W;
`ifdef CRANK_WHEEL_GEN_CAM_EN
                    rp_d     = 1'b0;
`endif
                end
            end
            RUN: begin
                if (!ena) begin
                    // Abort immediately; the current slot is not completed.
                    state_d  = IDLE;
                    scnt_d   = '0;
                    tcnt_d   = START_W;
                    per_sh_d = PER_MIN_W;
`ifdef CRANK_WHEEL_GEN_CAM_EN
                    rp_d     = 1'b0;
`endif
                end else if (scnt_q == per_sh_q - PER_WIDTH'(1)) begin
                    scnt_d   = '0;
                    per_sh_d = per_clamp;
                    if (tcnt_q == LAST_W) begin
                        tcnt_d = '0;
`ifdef CRANK_WHEEL_GEN_CAM_EN
                        rp_d   = ~rp_q;
`endif
                    end else begin
                        tcnt_d = tcnt_q + TCNT_WIDTH'(1);
                    end
                end else begin
                    scnt_d = scnt_q + PER_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are derived from the next-state counters so they line up with them.
        run_d     = (state_d == RUN);
        present_d = (tcnt_d < PRESENT_LIM);
        cap_d     = inv ^ (run_d & present_d & (scnt_d < (per_sh_d >> 1)));
        gap_d     = run_d & ~present_d;
        rev_d     = run_d & (tcnt_d == '0) & (scnt_d == '0);
`ifdef CRANK_WHEEL_GEN_CAM_EN
        cam_d     = run_d & ~rp_d & (tcnt_d < CAM_W);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            scnt_q   <= '0;
            tcnt_q   <= START_W;
            per_sh_q <= PER_MIN_W;
            cap_q    <= 1'b0;
            gap_q    <= 1'b0;
            rev_q    <= 1'b0;
            run_q    <= 1'b0;
`ifdef CRANK_WHEEL_GEN_CAM_EN
            rp_q     <= 1'b0;
            cam_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            scnt_q   <= scnt_d;
            tcnt_q   <= tcnt_d;
            per_sh_q <= per_sh_d;
            cap_q    <= cap_d;
            gap_q    <= gap_d;
            rev_q    <= rev_d;
            run_q    <= run_d;
`ifdef CRANK_WHEEL_GEN_CAM_EN
            rp_q     <= rp_d;
            cam_q    <= cam_d;
`endif
        end
    end

    // While reset is held the sensor line sits at its idle level without waiting for a clock.
    assign cap        = rst ? cap_q : inv;
    assign tooth_num  = tcnt_q;
    assign gap        = gap_q;
    assign rev_strobe = rev_q;
    assign running    = run_q;
`ifdef CRANK_WHEEL_GEN_CAM_EN
    assign cam        = cam_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_crank_wheel_gen.sv
// ============================================================================
// tb_crank_wheel_gen : directed and random checks of crank_wheel_gen.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_crank_wheel_gen;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [23:0] period;
    logic        inv;
    logic        cap;
    logic [5:0]  tooth_num;
    logic        gap;
    logic        rev_strobe;
    logic        running;
`ifdef CRANK_WHEEL_GEN_CAM_EN
    logic        cam;
`endif

    int total = 0;
    int bad   = 0;

    // Reference: slot-based view of the wheel (tooth, offset into slot, slot length).
    bit m_run   = 0;
    int m_tooth = 0;
    int m_off   = 0;
    int m_len   = 4;
    int m_revs  = 0;

    crank_wheel_gen dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .period     (period),
        .inv        (inv),
        .cap        (cap),
        .tooth_num  (tooth_num),
        .gap        (gap),
        .rev_strobe (rev_strobe),
        .running    (running)
`ifdef CRANK_WHEEL_GEN_CAM_EN
        ,
        .cam        (cam)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clampp(input int p);
        return (p < 4) ? 4 : p;
    endfunction

    task automatic model_update(input bit e, input int p);
        if (!e) begin
            m_run = 0;
        end else if (!m_run) begin
            m_run = 1; m_tooth = 0; m_off = 0; m_len = clampp(p); m_revs = 0;
        end else begin
            m_off++;
            if (m_off >= m_len) begin
                m_off = 0;
                m_len = clampp(p);
                if (m_tooth == 59) begin
                    m_tooth = 0;
                    m_revs++;
                end else begin
                    m_tooth++;
                end
            end
        end
    endtask

    task automatic model_check(input bit iv);
        bit present;
        present = (m_tooth < 58);
        chk("m_running", {31'd0, running}, {31'd0, m_run});
        chk("m_tooth", {26'd0, tooth_num}, m_run ? m_tooth : 0);
        chk("m_cap", {31'd0, cap}, {31'd0, iv ^ (m_run && present && (m_off < m_len / 2))});
        chk("m_gap", {31'd0, gap}, {31'd0, m_run && !present});
        chk("m_rev", {31'd0, rev_strobe}, {31'd0, m_run && m_tooth == 0 && m_off == 0});
`ifdef CRANK_WHEEL_GEN_CAM_EN
        chk("m_cam", {31'd0, cam}, {31'd0, m_run && (m_revs % 2 == 0) && m_tooth < 4});
`endif
    endtask

    task automatic step(input bit e, input int p, input bit iv);
        ena = e; period = 24'(p); inv = iv;
        @(posedge clk);
        #1;
        model_update(e, p);
        model_check(iv);
    endtask

    initial begin
        rst = 1'b0; ena = 1'b0; period = 24'd8; inv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cap", {31'd0, cap}, 0);
        chk("rst_running", {31'd0, running}, 0);
        chk("rst_tooth", {26'd0, tooth_num}, 0);
        chk("rst_gap", {31'd0, gap}, 0);
        chk("rst_rev", {31'd0, rev_strobe}, 0);
        @(negedge clk);
        rst = 1'b1;

        // Regular 60-2 train at period 8, closed-form expectations per cycle.
        for (int t = 0; t < 1000; t++) begin
            int tooth;
            step(1, 8, 0);
            tooth = (t / 8) % 60;
            chk("train_cap", {31'd0, cap}, {31'd0, (tooth < 58) && (t % 8 < 4)});
            chk("train_tooth", {26'd0, tooth_num}, tooth);
            chk("train_gap", {31'd0, gap}, {31'd0, tooth >= 58});
            chk("train_rev", {31'd0, rev_strobe}, {31'd0, t % 480 == 0});
`ifdef CRANK_WHEEL_GEN_CAM_EN
            chk("train_cam", {31'd0, cam}, {31'd0, ((t / 480) % 2 == 0) && tooth < 4});
`endif
        end

        // Period change during tooth 0 takes effect from tooth 1.
        step(0, 8, 0);
        for (int t = 0; t < 26; t++) begin
            step(1, (t < 3) ? 8 : 12, 0);
            if (t == 7)  chk("pc_t7_tooth", {26'd0, tooth_num}, 0);
            if (t == 8)  chk("pc_t8_tooth", {26'd0, tooth_num}, 1);
            if (t == 13) chk("pc_t13_cap", {31'd0, cap}, 1);
            if (t == 14) chk("pc_t14_cap", {31'd0, cap}, 0);
            if (t == 19) chk("pc_t19_tooth", {26'd0, tooth_num}, 1);
            if (t == 20) chk("pc_t20_tooth", {26'd0, tooth_num}, 2);
            if (t == 20) chk("pc_t20_cap", {31'd0, cap}, 1);
        end

        // Clamped period 1 -> 4 clocks per slot.
        step(0, 8, 0);
        for (int t = 0; t < 20; t++) begin
            step(1, 1, 0);
            chk("clamp_cap", {31'd0, cap}, {31'd0, t % 4 < 2});
            chk("clamp_tooth", {26'd0, tooth_num}, t / 4);
        end

        // Odd period 9: high 4, low 5.
        step(0, 8, 0);
        for (int t = 0; t < 36; t++) begin
            step(1, 9, 0);
            chk("odd_cap", {31'd0, cap}, {31'd0, t % 9 < 4});
            chk("odd_tooth", {26'd0, tooth_num}, t / 9);
        end

        // Stop mid tooth 12 and restart ten cycles later.
        step(0, 8, 0);
        for (int t = 0; t <= 100; t++) step(1, 8, 0);
        step(0, 8, 0);
        chk("stop_cap", {31'd0, cap}, 0);
        chk("stop_running", {31'd0, running}, 0);
        chk("stop_tooth", {26'd0, tooth_num}, 0);
        for (int t = 102; t < 110; t++) step(0, 8, 0);
        step(1, 8, 0);
        chk("restart_rev", {31'd0, rev_strobe}, 1);
        chk("restart_tooth", {26'd0, tooth_num}, 0);
        chk("restart_cap", {31'd0, cap}, 1);

        // Inverted polarity gives the complement of the regular train.
        step(0, 8, 1);
        for (int t = 0; t < 60; t++) begin
            step(1, 8, 1);
            chk("inv_cap", {31'd0, cap}, {31'd0, !(t % 8 < 4)});
        end

        // Random periods, enables and polarity against the reference.
        step(0, 8, 0);
        begin
            bit iv;
            iv = 0;
            for (int n = 0; n < 2000; n++) begin
                bit e;
                e = ($urandom_range(0, 399) != 0);
                if ($urandom_range(0, 49) == 0) iv = ~iv;
                step(e, int'($urandom_range(0, 7)), iv);
            end
        end

        // Asynchronous reset between edges during a high phase.
        step(0, 8, 0);
        step(1, 8, 0);
        step(1, 8, 0);
        chk("ar_pre_cap", {31'd0, cap}, 1);
        #3;
        rst = 1'b0;
        #1;
        chk("ar_cap", {31'd0, cap}, 0);
        chk("ar_running", {31'd0, running}, 0);
        chk("ar_tooth", {26'd0, tooth_num}, 0);
        inv = 1'b1;
        #1;
        chk("ar_cap_inv", {31'd0, cap}, 1);
        m_run = 0;
        @(negedge clk);
        inv = 1'b0;
        rst = 1'b1;
        step(0, 8, 0);
        step(1, 8, 0);
        chk("ar_restart_rev", {31'd0, rev_strobe}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/crank_wheel_gen.md
Name: crank_wheel_gen

Overview:
- Synthetic crankshaft-sensor signal generator, the transmit side of the crank capture path.
- Produces an N-minus-M toothed-wheel pulse train (default 60-2) at a programmable tooth period in clocks.
- Used on the FPGA as a bench/stand-alone stimulus source feeding the angle generator's capture input, and for engine-simulator builds.
- Also reports the current tooth number and a once-per-revolution strobe.

Parameters:
- PER_WIDTH, 24, width of the tooth period in clocks.
- TCNT_WIDTH, 6, width of the tooth index.
- TEETH_TOTAL, 60, tooth slots per revolution, including missing ones.
- TEETH_MISSING, 2, absent teeth at the end of the revolution.
- START_TOOTH, 0, tooth index loaded on start.
- PER_MIN, 4, minimum accepted period.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- ena  in  1  run enable, level-sensitive.
- period  in  PER_WIDTH  clocks per tooth slot; sampled only at slot boundaries.
- inv  in  1  output polarity: 0 = tooth is high, 1 = tooth is low.
- cap  out  1  generated sensor signal (registered).
- tooth_num  out  TCNT_WIDTH  current slot index, 0..TEETH_TOTAL-1.
- gap  out  1  high while the current slot is a missing tooth.
- rev_strobe  out  1  one-clock pulse at the start of slot 0.
- running  out  1  high in RUN state.

Behaviour:
- State machine has two states: IDLE and RUN.
- Reset (rst=0) forces the following, asynchronously, regardless of clock:
  - state IDLE;
  - internal slot counter scnt=0;
  - tooth counter tcnt=START_TOOTH;
  - period shadow per_sh=PER_MIN;
  - cap=inv (idle level);
  - gap=0, rev_strobe=0, running=0.
  - tooth_num=tcnt at all times.
- IDLE -> RUN at the first posedge with ena=1. At that edge:
  - per_sh <= max(period, PER_MIN);
  - scnt <= 0; tcnt <= START_TOOTH.
- RUN -> IDLE at any posedge with ena=0. At that edge:
  - counters return to their reset values;
  - cap <= inv; other outputs <= 0.
  - No completion of the current slot.
- RUN, each clock:
  - if scnt == per_sh-1: end of slot.
    - scnt <= 0.
    - tcnt <= (tcnt == TEETH_TOTAL-1) ? 0 : tcnt+1.
    - per_sh <= max(period, PER_MIN). A new period therefore takes effect only from the next slot, so there are no truncated teeth.
  - otherwise scnt <= scnt+1.
- Slot classification:
  - present tooth: tcnt < TEETH_TOTAL-TEETH_MISSING;
  - missing tooth: all other slots.
- Outputs are registered and computed from the post-edge counter values, so they are aligned with the counters with zero extra latency.
  - cap = inv XOR (present AND scnt < per_sh>>1). High phase is floor(per_sh/2) clocks, starting at scnt=0.
  - gap = running AND NOT present.
  - rev_strobe = 1 for exactly the clock where tcnt==0 AND scnt==0 in RUN. This includes the start cycle when START_TOOTH=0.
- Width rules:
  - per_sh width is PER_WIDTH; the comparison scnt == per_sh-1 is unsigned.
  - An odd period gives the extra clock to the low phase.
  - period values 0..PER_MIN-1 are clamped to PER_MIN.
- Edge cases:
  - A period change in the last clock of a slot is captured for the next slot.
  - inv changes apply on the next clock and may glitch the level once; this is allowed.

Optional Feature:
- Macro: CRANK_WHEEL_GEN_CAM_EN.
- When defined:
  - adds a port cam, out, 1, and an internal revolution-parity bit rp (reset 0, toggled at every slot-0 start after the first);
  - adds a parameter CAM_TEETH, default 4;
  - cam = 1 while running AND rp==0 AND tcnt < CAM_TEETH, i.e. one cam pulse every two revolutions (4-stroke phase);
  - cam is not affected by inv.
- When not defined: no cam port, no rp register, behaviour otherwise identical.

Test Plan:
- Regular train: rst released, period=8, inv=0, ena=1 at cycle 0.
  - cap rises at cycles 0, 8, ..., 456 (tooth 57), each high for 4 clocks.
  - Next rise at 480, so the gap is low for 20 clocks (456+4..479).
  - rev_strobe at 0 and 480; gap=1 for cycles 464..479.
- Period change: period=8, then period changed to 12 at cycle 3.
  - Tooth 0 stays 8 clocks.
  - Tooth 1 starts at cycle 8 and lasts 12 clocks (high 6).
  - Tooth 2 rises at cycle 20.
- Clamp and odd period:
  - period=1: every slot is 4 clocks, high 2.
  - period=9: high 4, low 5.
- Stop and restart: ena deasserted at cycle 100 (mid tooth 12).
  - Next clock: cap=0, running=0, tooth_num=0.
  - Re-enable at cycle 110: tooth 0 restarts at 110 with rev_strobe.
- Async reset and polarity: rst pulled low between clock edges during a high phase.
  - cap=inv immediately, without waiting for an edge.
  - With inv=1, the run of the regular-train scenario gives the exact complement of the expected cap waveform.
- CAM_EN build, period=8, CAM_TEETH=4:
  - cam high for cycles 0..31, low through revolution 2 (480..959);
  - high again for 960..991.
